// File: rtl/lsu_ram_master.sv
// Load/store initiator for the word-wide on-chip RAM: lane extraction, sign/zero
// extension, read-modify-write for SB/SH, and early rejection of bad accesses.
module lsu_ram_master #(
  parameter int AW = 14
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rden,
  output logic        mem_wren,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rden_q;
  logic        wren_q;
  logic        req_err;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  // Strobes are masked during reset so an in-flight access never reaches the RAM.
  assign mem_rden  = rden_q && !p_reset;
  assign mem_wren  = wren_q && !p_reset;

  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (req_funct3 >= 3'd3) req_err = 1'b1;
    end else if (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11) begin
      req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ((req_addr >> AW) != 32'd0) req_err = 1'b1;
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3_q[1:0])
      2'b00:   load_data = {{24{byte_lane[7] & ~funct3_q[2]}}, byte_lane};
      2'b01:   load_data = {{16{half_lane[15] & ~funct3_q[2]}}, half_lane};
      default: load_data = mem_rdata;
    endcase

    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= 32'd0;
            end else begin
              we_q     <= req_we;
              funct3_q <= req_funct3;
              addr_q   <= req_addr;
              wdata_q  <= req_wdata;
              // Full-word stores skip the read; everything else reads first.
              if (req_we && req_funct3 == 3'd2) begin
                mem_wdata <= req_wdata;
                wren_q    <= 1'b1;
                state     <= WR;
              end else begin
                rden_q <= 1'b1;
                state  <= RD;
              end
            end
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          if (we_q) begin
            mem_wdata <= merged;
            wren_q    <= 1'b1;
            state     <= WR;
          end else begin
            resp_data  <= load_data;
            resp_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_data  <= 32'd0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master with a behavioural word RAM attached to the
// memory port; expected values are hand-computed from the preloaded contents.
module tb_lsu_ram_master;

  logic        m_clock = 1'b0;
  logic        p_reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_rdata;

  logic        bd_we = 1'b0;
  logic [11:0] bd_idx = 12'd0;
  logic [31:0] bd_data = 32'd0;
  logic [31:0] ram [0:4095];

  int checks = 0;
  int errors = 0;

  lsu_ram_master #(.AW(14)) dut (
    .m_clock(m_clock), .p_reset(p_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  always #5 m_clock = ~m_clock;

  // Synchronous RAM: read data appears the cycle after mem_rden.
  always @(posedge m_clock) begin
    if (bd_we) ram[bd_idx] <= bd_data;
    if (mem_wren) ram[mem_addr[13:2]] <= mem_wdata;
    if (mem_rden) mem_rdata <= ram[mem_addr[13:2]];
  end

  // Issues one request and observes the DUT until its response or a 20-cycle budget.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic err,
                         output logic [31:0] data, output int rd_n, output int wr_n,
                         output int wr_cyc, output logic [31:0] r_addr,
                         output logic [31:0] w_addr, output logic [31:0] w_data);
    lat = 0; err = 1'b0; data = 32'hxxxx_xxxx; rd_n = 0; wr_n = 0; wr_cyc = 0;
    r_addr = 32'hxxxx_xxxx; w_addr = 32'hxxxx_xxxx; w_data = 32'hxxxx_xxxx;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge m_clock); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_rden) begin rd_n++; r_addr = mem_addr; end
      if (mem_wren) begin wr_n++; wr_cyc = c; w_addr = mem_addr; w_data = mem_wdata; end
      if (resp_valid) begin lat = c; err = resp_err; data = resp_data; break; end
      @(posedge m_clock); #1;
    end
  endtask

  task automatic test_reset();
    p_reset = 1'b1;
    bd_we = 1'b1; bd_idx = 12'd4; bd_data = 32'h8899_AABB;
    @(posedge m_clock); #1;
    bd_we = 1'b0;
    @(posedge m_clock); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_resp_data got %h want 0", resp_data); end
    checks++; if ({mem_rden, mem_wren} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes got %b want 00", {mem_rden, mem_wren}); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    p_reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd2};
    logic [31:0] adrs [4] = '{32'h11, 32'h11, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h8899_AABB};
    int lat, rd_n, wr_n, wr_cyc;
    logic err;
    logic [31:0] data, r_addr, w_addr, w_data;
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, f3s[i], adrs[i], 32'd0, lat, err, data, rd_n, wr_n, wr_cyc, r_addr, w_addr, w_data);
      checks++; if (lat !== 3 || err !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_latency got lat=%0d err=%b want lat=3 err=0", i, lat, err); end
      checks++; if (data !== exps[i]) begin errors++; $display("[TB] FAIL load%0d_data got %h want %h", i, data, exps[i]); end
      checks++; if (rd_n !== 1 || wr_n !== 0 || r_addr !== 32'h10) begin errors++; $display("[TB] FAIL load%0d_strobes got rd=%0d wr=%0d addr=%h want 1 0 00000010", i, rd_n, wr_n, r_addr); end
    end
  endtask

  task automatic test_sb();
    int lat, rd_n, wr_n, wr_cyc;
    logic err;
    logic [31:0] data, r_addr, w_addr, w_data;
    run_req(1'b1, 3'd0, 32'h13, 32'h0000_0055, lat, err, data, rd_n, wr_n, wr_cyc, r_addr, w_addr, w_data);
    checks++; if (lat !== 4 || err !== 1'b0 || data !== 32'd0) begin errors++; $display("[TB] FAIL sb_resp got lat=%0d err=%b data=%h want 4 0 0", lat, err, data); end
    checks++; if (rd_n !== 1 || wr_n !== 1 || wr_cyc !== 3) begin errors++; $display("[TB] FAIL sb_strobes got rd=%0d wr=%0d wrcyc=%0d want 1 1 3", rd_n, wr_n, wr_cyc); end
    checks++; if (r_addr !== 32'h10 || w_addr !== 32'h10) begin errors++; $display("[TB] FAIL sb_addr got rd=%h wr=%h want 00000010", r_addr, w_addr); end
    checks++; if (w_data !== 32'h5599_AABB) begin errors++; $display("[TB] FAIL sb_wdata got %h want 5599aabb", w_data); end
    run_req(1'b0, 3'd2, 32'h10, 32'd0, lat, err, data, rd_n, wr_n, wr_cyc, r_addr, w_addr, w_data);
    checks++; if (data !== 32'h5599_AABB || lat !== 3) begin errors++; $display("[TB] FAIL sb_readback got %h lat=%0d want 5599aabb lat=3", data, lat); end
  endtask

  task automatic test_sw();
    int lat, rd_n, wr_n, wr_cyc;
    logic err;
    logic [31:0] data, r_addr, w_addr, w_data;
    run_req(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, lat, err, data, rd_n, wr_n, wr_cyc, r_addr, w_addr, w_data);
    checks++; if (lat !== 2 || err !== 1'b0 || data !== 32'd0) begin errors++; $display("[TB] FAIL sw_resp got lat=%0d err=%b data=%h want 2 0 0", lat, err, data); end
    checks++; if (rd_n !== 0 || wr_n !== 1 || wr_cyc !== 1) begin errors++; $display("[TB] FAIL sw_strobes got rd=%0d wr=%0d wrcyc=%0d want 0 1 1", rd_n, wr_n, wr_cyc); end
    checks++; if (w_addr !== 32'h20 || w_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sw_bus got %h/%h want 00000020/deadbeef", w_addr, w_data); end
    run_req(1'b0, 3'd2, 32'h20, 32'd0, lat, err, data, rd_n, wr_n, wr_cyc, r_addr, w_addr, w_data);
    checks++; if (data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sw_readback got %h want deadbeef", data); end
  endtask

  task automatic test_errors();
    logic        wes  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s  [4] = '{3'd1, 3'd2, 3'd3, 3'd2};
    logic [31:0] adrs [4] = '{32'h11, 32'h22, 32'h10, 32'h0000_4000};
    int lat, rd_n, wr_n, wr_cyc;
    logic err;
    logic [31:0] data, r_addr, w_addr, w_data;
    for (int i = 0; i < 4; i++) begin
      run_req(wes[i], f3s[i], adrs[i], 32'h1234_5678, lat, err, data, rd_n, wr_n, wr_cyc, r_addr, w_addr, w_data);
      checks++; if (lat !== 1 || err !== 1'b1 || data !== 32'd0) begin errors++; $display("[TB] FAIL err%0d_resp got lat=%0d err=%b data=%h want 1 1 0", i, lat, err, data); end
      checks++; if (rd_n !== 0 || wr_n !== 0) begin errors++; $display("[TB] FAIL err%0d_strobes got rd=%0d wr=%0d want 0 0", i, rd_n, wr_n); end
    end
    // The store to 0x22 was rejected, so word 0x20 must still hold the earlier value.
    run_req(1'b0, 3'd2, 32'h20, 32'd0, lat, err, data, rd_n, wr_n, wr_cyc, r_addr, w_addr, w_data);
    checks++; if (data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL err_no_write got %h want deadbeef", data); end
  endtask

  task automatic test_reset_in_wr();
    int lat, rd_n, wr_n, wr_cyc, resp_seen;
    logic err;
    logic [31:0] data, r_addr, w_addr, w_data;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h12; req_wdata = 32'h0000_1234;
    @(posedge m_clock); #1;
    req_valid = 1'b0;
    @(posedge m_clock); #1;
    @(posedge m_clock); #1;
    p_reset = 1'b1;
    #1;
    checks++; if (mem_wren !== 1'b0 || mem_rden !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr_strobe got wren=%b rden=%b want 0 0", mem_wren, mem_rden); end
    @(posedge m_clock); #1;
    p_reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_wr_ready got %b want 1", req_ready); end
    resp_seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (resp_valid) resp_seen++;
      @(posedge m_clock); #1;
    end
    checks++; if (resp_seen !== 0) begin errors++; $display("[TB] FAIL rst_wr_no_resp got %0d responses want 0", resp_seen); end
    run_req(1'b0, 3'd2, 32'h10, 32'd0, lat, err, data, rd_n, wr_n, wr_cyc, r_addr, w_addr, w_data);
    checks++; if (data !== 32'h5599_AABB) begin errors++; $display("[TB] FAIL rst_wr_ram got %h want 5599aabb", data); end
  endtask

  task automatic test_back_to_back();
    int lat, rd_n, wr_n, wr_cyc, first;
    logic err;
    logic [31:0] data, r_addr, w_addr, w_data;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge m_clock); #1;
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFE_F00D;
    first = 0;
    for (int c = 1; c <= 10; c++) begin
      if (resp_valid) begin first = c; break; end
      @(posedge m_clock); #1;
    end
    checks++; if (first !== 3 || resp_data !== 32'h5599_AABB) begin errors++; $display("[TB] FAIL b2b_first got cyc=%0d data=%h want 3 5599aabb", first, resp_data); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_with_resp got %b want 1", req_ready); end
    @(posedge m_clock); #1;
    req_valid = 1'b0;
    checks++; if (mem_wren !== 1'b1 || mem_addr !== 32'h14 || mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL b2b_sw_write got wren=%b %h/%h want 1 00000014/cafef00d", mem_wren, mem_addr, mem_wdata); end
    @(posedge m_clock); #1;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_sw_resp got valid=%b err=%b want 1 0", resp_valid, resp_err); end
    run_req(1'b0, 3'd2, 32'h14, 32'd0, lat, err, data, rd_n, wr_n, wr_cyc, r_addr, w_addr, w_data);
    checks++; if (data !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL b2b_readback got %h want cafef00d", data); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sb();
    test_sw();
    test_errors();
    test_reset_in_wr();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
